// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM encoding and the bitwise helper functions shared by
// the compression core and its round sub-module.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  // Working variables; a sits in the top word so the struct lines up with
  // the digest layout (H0 in the MSBs).
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: (a..h, K[t], W[t]) -> next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1, t2;

  always_comb begin
    t1    = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2    = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt   = cur;
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256.sv
// Iterative SHA-256 compression core: one 512-bit pre-padded block per
// handshake, one round per clock, digest held until the consumer takes it.
module sha256
  import sha256_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         new_hash,
  input  logic [511:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [255:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t            state, state_nxt;
  logic [5:0]        t;
  logic [0:15][31:0] sched;
  logic [31:0]       w_new;
  work_t             work, work_nxt;
  logic [7:0][31:0]  chain, chain_sel, work_w, digest;
  logic              accept;

  assign in_ready  = rst_i && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;

  assign chain_sel = new_hash ? IV : chain;
  assign work_w    = work;

  // sched[0] is always W[t]; the word shifted in is W[t+16]. Words produced
  // past t=47 are never consumed, which keeps the shift unconditional.
  assign w_new = ssig1(sched[14]) + sched[9] + ssig0(sched[1]) + sched[0];

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) digest[i] = chain[i] + work_w[i];
  end

  sha256_round u_round (
    .cur (work),
    .k   (K[t]),
    .w   (sched[0]),
    .nxt (work_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)    state_nxt = ROUND;
      ROUND:   if (t == 6'd63)  state_nxt = FINAL;
      FINAL:                    state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // chain holds the value being chained from until FINAL replaces it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      t     <= '0;
      chain <= IV;
      out   <= '0;
    end else begin
      if (accept) begin
        t     <= '0;
        chain <= chain_sel;
      end else if (state == ROUND) begin
        t <= t + 6'd1;
      end else if (state == FINAL) begin
        chain <= digest;
        out   <= digest;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      sched <= in;
      work  <= chain_sel;
    end else if (state == ROUND) begin
      sched <= {sched[1:15], w_new};
      work  <= work_nxt;
    end
  end

endmodule

// File: tb/tb_sha256.sv
// Bench for the SHA-256 core: known-answer table, backpressure and abort
// sequences, then random blocks against a full-array reference compression.
module tb_sha256;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         new_hash;
  logic [511:0] in_blk;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] out;
  logic         out_valid;
  logic         out_ready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  sha256 dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .new_hash  (new_hash),
    .in        (in_blk),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  localparam logic [255:0] H_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_EXP   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_EXP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] TWO_B1    = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_EXP   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // Reference compression straight from the algorithm: full 64-word W array.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x); return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22); endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x); return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25); endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x); return ror(x, 7) ^ ror(x, 18) ^ (x >> 3); endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x); return ror(x, 17) ^ ror(x, 19) ^ (x >> 10); endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int r_i = 0; r_i < 64; r_i++) begin
      t1 = v[7] + bs1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r_i] + w[r_i];
      t2 = bs0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Offers one block, counts edges from the accepting one (edge 1) until
  // out_valid shows, and compares the digest. Leaves the DUT in DONE.
  task automatic run_block(input logic nh, input logic [511:0] blk, input logic [255:0] exp,
                           input bit hold, input bit noise, input string nm);
    int lat;
    @(negedge clk_i);
    in_blk = blk; new_hash = nh; in_valid = 1'b1; out_ready = 1'b0;
    chk({nm, "_in_ready"}, 256'(in_ready), 256'(1));
    @(posedge clk_i);
    lat = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk_i);
      if (!hold) begin
        in_valid = 1'b0;
        new_hash = ~nh;
        in_blk   = {16{$urandom}};
      end
      if (out_valid) begin
        lat = c;
        break;
      end
      out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk_i);
    end
    out_ready = 1'b0;
    chk({nm, "_latency"}, 256'(lat), 256'(66));
    chk({nm, "_digest"}, out, exp);
  endtask

  // Called at a negedge with the DUT in DONE.
  task automatic consume(input logic [255:0] exp, input string nm);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready = 1'b0;
    chk({nm, "_idle_ready"}, 256'(in_ready), 256'(1));
    chk({nm, "_idle_valid"}, 256'(out_valid), 256'(0));
    chk({nm, "_out_held"}, out, exp);
  endtask

  typedef struct {
    logic         nh;
    logic [511:0] blk;
    logic [255:0] exp;
  } vec_t;

  vec_t         vt [4];
  logic [255:0] mc, exp_r;
  logic [511:0] rb;
  logic         rnh;
  int           bad;

  initial begin
    vt[0] = '{1'b0, EMPTY_BLK, EMPTY_EXP};   // new_hash=0 right after reset
    vt[1] = '{1'b1, ABC_BLK,   ABC_EXP};
    vt[2] = '{1'b1, TWO_B1,    ref_compress(H_IV, TWO_B1)};
    vt[3] = '{1'b0, TWO_B2,    TWO_EXP};

    rst_i = 1'b0; new_hash = 1'b0; in_blk = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out", out, 256'(0));
    rst_i = 1'b1;
    #1;
    chk("release_in_ready", 256'(in_ready), 256'(1));

    for (int i = 0; i < 4; i++) begin
      run_block(vt[i].nh, vt[i].blk, vt[i].exp, 1'b0, 1'b0, $sformatf("vec%0d", i));
      consume(vt[i].exp, $sformatf("vec%0d", i));
    end

    // in_valid stays high through the computation and a stalled DONE.
    run_block(1'b1, ABC_BLK, ABC_EXP, 1'b1, 1'b0, "bp");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (out !== ABC_EXP || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("bp_stall_stable", 256'(bad), 256'(0));
    consume(ABC_EXP, "bp");

    // Abort at round 30, then chain from the restored IV with new_hash=0.
    @(negedge clk_i);
    in_blk = EMPTY_BLK; new_hash = 1'b1; in_valid = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid = 1'b0;
    repeat (30) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("abort_in_ready", 256'(in_ready), 256'(0));
    chk("abort_out_valid", 256'(out_valid), 256'(0));
    chk("abort_out", out, 256'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chk("abort_no_result", 256'(bad), 256'(0));
    run_block(1'b0, ABC_BLK, ABC_EXP, 1'b0, 1'b0, "abort_abc");
    consume(ABC_EXP, "abort_abc");

    // Random blocks with random chaining, out_ready toggling while busy.
    mc = H_IV;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom;
      rnh = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_r = ref_compress(rnh ? H_IV : mc, rb);
      mc = exp_r;
      run_block(rnh, rb, exp_r, 1'b0, 1'b1, $sformatf("rand%0d", i));
      consume(exp_r, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sha256.md
SHA256 -- requirements
Module: sha256

Interface
- REQ-001: Parameters: none; all widths fixed by FIPS 180-4.
- REQ-002: clk_i  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_i  input  1  reset, synchronous, active-low.
- REQ-004: new_hash  input  1  sampled at block acceptance: 1 = start from the IV, 0 = chain from the previous digest.
- REQ-005: in  input  512  one pre-padded message block; in[511:480] = W0 … in[31:0] = W15, big-endian words.
- REQ-006: in_valid  input  1  block offered.
- REQ-007: in_ready  output  1  block can be accepted.
- REQ-008: out  output  256  digest; out[255:224] = H0 … out[31:0] = H7.
- REQ-009: out_valid  output  1  digest available.
- REQ-010: out_ready  input  1  consumer takes the digest.

Function
- REQ-011: Shall compute one SHA-256 compression per accepted block; no padding or length insertion (the caller supplies padded blocks).
- REQ-012: FSM states: IDLE, ROUND, FINAL, DONE.
- REQ-013: IDLE: in_ready=1, out_valid=0; on in_valid&in_ready:
  - latch the block;
  - select the chaining value (IV if new_hash=1, else the stored digest);
  - load a..h from that value;
  - go to ROUND with round counter 0.
- REQ-014: ROUND: one round per cycle using K[t] and W[t] (W16..63 via σ0/σ1 on a 16-word rolling schedule); exit to FINAL after t=63 (exactly 64 cycles).
- REQ-015: FINAL: Hi = chain_i + working_i (mod 2^32 each); store as new chaining digest and drive on out; go to DONE.
- REQ-016: out_valid shall first be high 66 cycles after the accepting edge (1 load + 64 rounds + 1 final).
- REQ-017: DONE: out_valid=1, in_ready=0; out held stable until out_ready=1, then return to IDLE next cycle.
- REQ-018: in_valid and new_hash shall be ignored in ROUND, FINAL and DONE; a continuously high in_valid shall not cause re-acceptance before the digest is consumed.
- REQ-019: After a handshake, out shall keep the last digest until the next FINAL overwrites it.
- REQ-020: out_ready while out_valid=0 shall have no effect.
- REQ-021: new_hash=0 on the first block after reset chains from the IV (stored digest resets to the IV).

Reset
- REQ-022: When rst_i=0 at a clock edge:
  - state=IDLE, round counter=0;
  - out=0, out_valid=0;
  - stored digest = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
- REQ-023: in_ready shall be 0 while rst_i=0 and 1 the first cycle after release.
- REQ-024: Reset mid-computation or in DONE shall abort without producing out_valid.

Structure
- REQ-025: Package sha256_pkg holds:
  - the 64-entry K constant table;
  - the 8-word IV;
  - the FSM state enum;
  - Σ0/Σ1/σ0/σ1/Ch/Maj functions.
- REQ-026: One combinational sub-module, sha256_round, maps (a..h, K[t], W[t]) to the next a..h; the top holds FSM, schedule and registers.

Verification
- REQ-027: "abc" block 61626380 00…00 00000018, new_hash=1 -> out_valid at +66 cycles, out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- REQ-028: Empty-message block 80000000 00…00, new_hash=1 -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- REQ-029: Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 with new_hash=1, consume the intermediate digest;
  - block 2 with new_hash=0;
  - required: 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- REQ-030: Backpressure: out_ready=0 for 10 cycles after out_valid with in_valid held 1 -> out stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE next cycle.
- REQ-031: rst_i=0 at round 30 -> next cycle in_ready=0, out_valid=0, out=0; after release, "abc" with new_hash=0 still yields ba7816bf….
